// File: rtl/dma_ctrl_pkg.sv
// Shared constants, register map and state encoding for the
// single-channel byte-copy DMA controller.
package dma_ctrl_pkg;

   localparam int BUS_ADDR_WIDTH = 10;
   localparam int DATA_WIDTH     = 8;

   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   localparam logic [2:0] OFS_SRC_L  = 3'd0;
   localparam logic [2:0] OFS_SRC_H  = 3'd1;
   localparam logic [2:0] OFS_DST_L  = 3'd2;
   localparam logic [2:0] OFS_DST_H  = 3'd3;
   localparam logic [2:0] OFS_LEN    = 3'd4;
   localparam logic [2:0] OFS_CTRL   = 3'd5;
   localparam logic [2:0] OFS_STATUS = 3'd6;
   localparam logic [2:0] OFS_REMAIN = 3'd7;

   localparam int CTRL_START = 0;
   localparam int CTRL_ABORT = 1;
   localparam int CTRL_IE    = 2;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_ABORTED = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_RD,
      ST_WR,
      ST_DONE
   } state_t;

endpackage

// File: rtl/dma_ctrl_regs.sv
// CPU-visible register file of the DMA: config storage, read mux
// and the start/abort strobes decoded from CTRL writes.
module dma_regs
   import dma_ctrl_pkg::*;
#(
   parameter int ADDR_W = BUS_ADDR_WIDTH,
   parameter int DATA_W = DATA_WIDTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        cfg_addr,
   input  logic              cfg_we,
   input  logic [DATA_W-1:0] cfg_wdata,
   output logic [DATA_W-1:0] cfg_rdata,
   input  logic              idle,
   input  logic              set_done,
   input  logic              set_aborted,
   input  logic [DATA_W-1:0] remain,
   output logic [ADDR_W-1:0] src_cfg,
   output logic [ADDR_W-1:0] dst_cfg,
   output logic [DATA_W-1:0] len_cfg,
   output logic              ie,
   output logic              done,
   output logic              start_p,
   output logic              abort_p
);

   localparam int HI_W = ADDR_W - DATA_W;

   logic [DATA_W-1:0] src_l_q, src_l_d;
   logic [HI_W-1:0]   src_h_q, src_h_d;
   logic [DATA_W-1:0] dst_l_q, dst_l_d;
   logic [HI_W-1:0]   dst_h_q, dst_h_d;
   logic [DATA_W-1:0] len_q, len_d;
   logic              ie_q, ie_d;
   logic              done_q, done_d;
   logic              aborted_q, aborted_d;

   logic wr_cfg;
   logic wr_ctrl;
   logic wr_stat;
   logic clr_flags;

   assign wr_cfg  = cfg_we && idle;
   assign wr_ctrl = cfg_we && (cfg_addr == OFS_CTRL);
   assign wr_stat = cfg_we && (cfg_addr == OFS_STATUS);

   // abort has priority over start when both bits arrive together
   assign start_p = wr_ctrl && cfg_wdata[CTRL_START]
                    && !cfg_wdata[CTRL_ABORT] && idle;
   assign abort_p = wr_ctrl && cfg_wdata[CTRL_ABORT];

   assign clr_flags = start_p || wr_stat;

   always_comb begin
      src_l_d   = src_l_q;
      src_h_d   = src_h_q;
      dst_l_d   = dst_l_q;
      dst_h_d   = dst_h_q;
      len_d     = len_q;
      ie_d      = ie_q;
      done_d    = done_q;
      aborted_d = aborted_q;
      if (wr_cfg) begin
         unique case (cfg_addr)
            OFS_SRC_L: src_l_d = cfg_wdata;
            OFS_SRC_H: src_h_d = cfg_wdata[HI_W-1:0];
            OFS_DST_L: dst_l_d = cfg_wdata;
            OFS_DST_H: dst_h_d = cfg_wdata[HI_W-1:0];
            OFS_LEN:   len_d   = cfg_wdata;
            default: ;
         endcase
      end
      if (wr_ctrl) begin
         ie_d = cfg_wdata[CTRL_IE];
      end
      if (set_done) begin
         done_d = 1'b1;
      end else if (clr_flags) begin
         done_d = 1'b0;
      end
      if (set_aborted) begin
         aborted_d = 1'b1;
      end else if (clr_flags) begin
         aborted_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         src_l_q   <= '0;
         src_h_q   <= '0;
         dst_l_q   <= '0;
         dst_h_q   <= '0;
         len_q     <= '0;
         ie_q      <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         src_l_q   <= src_l_d;
         src_h_q   <= src_h_d;
         dst_l_q   <= dst_l_d;
         dst_h_q   <= dst_h_d;
         len_q     <= len_d;
         ie_q      <= ie_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   always_comb begin
      cfg_rdata = '0;
      unique case (cfg_addr)
         OFS_SRC_L:  cfg_rdata = src_l_q;
         OFS_SRC_H:  cfg_rdata[HI_W-1:0] = src_h_q;
         OFS_DST_L:  cfg_rdata = dst_l_q;
         OFS_DST_H:  cfg_rdata[HI_W-1:0] = dst_h_q;
         OFS_LEN:    cfg_rdata = len_q;
         OFS_CTRL:   cfg_rdata[CTRL_IE] = ie_q;
         OFS_STATUS: begin
            cfg_rdata[STAT_BUSY]    = !idle;
            cfg_rdata[STAT_DONE]    = done_q;
            cfg_rdata[STAT_ABORTED] = aborted_q;
         end
         OFS_REMAIN: cfg_rdata = remain;
         default: ;
      endcase
   end

   assign src_cfg = {src_h_q, src_l_q};
   assign dst_cfg = {dst_h_q, dst_l_q};
   assign len_cfg = len_q;
   assign ie      = ie_q;
   assign done    = done_q;

endmodule

// File: rtl/dma_ctrl.sv
// Single-channel DMA master: requests the shared bus and copies LEN
// bytes from SRC to DST as read-then-write pairs.
module dma_ctrl
   import dma_ctrl_pkg::*;
#(
   parameter int ADDR_W = BUS_ADDR_WIDTH,
   parameter int DATA_W = DATA_WIDTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        cfg_addr,
   input  logic              cfg_we,
   input  logic [DATA_W-1:0] cfg_wdata,
   output logic [DATA_W-1:0] cfg_rdata,
   output logic              bus_req,
   input  logic              bus_gnt,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              m_rw_,
   output logic              irq
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [DATA_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] buf_q, buf_d;

   logic              idle;
   logic              set_done;
   logic              set_aborted;
   logic [ADDR_W-1:0] src_cfg;
   logic [ADDR_W-1:0] dst_cfg;
   logic [DATA_W-1:0] len_cfg;
   logic              ie;
   logic              done;
   logic              start_p;
   logic              abort_p;

   assign idle = (state_q == ST_IDLE);

   dma_regs #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_regs (
      .clk         (clk),
      .reset       (reset),
      .cfg_addr    (cfg_addr),
      .cfg_we      (cfg_we),
      .cfg_wdata   (cfg_wdata),
      .cfg_rdata   (cfg_rdata),
      .idle        (idle),
      .set_done    (set_done),
      .set_aborted (set_aborted),
      .remain      (cnt_q),
      .src_cfg     (src_cfg),
      .dst_cfg     (dst_cfg),
      .len_cfg     (len_cfg),
      .ie          (ie),
      .done        (done),
      .start_p     (start_p),
      .abort_p     (abort_p)
   );

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      dst_d       = dst_q;
      cnt_d       = cnt_q;
      buf_d       = buf_q;
      set_done    = 1'b0;
      set_aborted = 1'b0;
      bus_req     = 1'b0;
      m_addr      = '0;
      m_wdata     = '0;
      m_rw_       = READ;
      unique case (state_q)
         ST_IDLE: begin
            if (start_p) begin
               src_d   = src_cfg;
               dst_d   = dst_cfg;
               cnt_d   = len_cfg;
               state_d = (len_cfg == '0) ? ST_DONE : ST_REQ;
            end
         end
         ST_REQ: begin
            bus_req = 1'b1;
            if (bus_gnt) begin
               state_d = ST_RD;
            end
            if (abort_p) begin
               state_d     = ST_IDLE;
               set_aborted = 1'b1;
            end
         end
         ST_RD: begin
            bus_req = 1'b1;
            m_addr  = src_q;
            if (bus_gnt) begin
               buf_d   = m_rdata;
               state_d = ST_WR;
            end
            if (abort_p) begin
               state_d     = ST_IDLE;
               set_aborted = 1'b1;
            end
         end
         ST_WR: begin
            bus_req = 1'b1;
            m_addr  = dst_q;
            m_wdata = buf_q;
            m_rw_   = WRITE;
            // a granted write completes even if aborted this cycle
            if (bus_gnt) begin
               src_d   = src_q + ADDR_W'(1);
               dst_d   = dst_q + ADDR_W'(1);
               cnt_d   = cnt_q - DATA_W'(1);
               state_d = (cnt_q == DATA_W'(1)) ? ST_DONE : ST_RD;
            end
            if (abort_p) begin
               state_d     = ST_IDLE;
               set_aborted = 1'b1;
            end
         end
         ST_DONE: begin
            set_done = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
      end
   end

   assign irq = done & ie;

endmodule

// File: tb/tb_dma_ctrl.sv
// Bench for dma_ctrl: bus-attached RAM model plus a byte-copy
// reference computed from the register settings.
module tb_dma_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] cfg_addr;
   logic       cfg_we;
   logic [7:0] cfg_wdata;
   logic [7:0] cfg_rdata;
   logic       bus_req;
   logic       bus_gnt;
   logic [9:0] m_addr;
   logic [7:0] m_wdata;
   logic [7:0] m_rdata;
   logic       m_rw_;
   logic       irq;

   logic [7:0]  mem [1024];
   logic [17:0] wq[$];
   bit          gnt_pat [512];
   logic        st_busy;
   logic        any_req;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   assign m_rdata = mem[m_addr];

   dma_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_addr  (cfg_addr),
      .cfg_we    (cfg_we),
      .cfg_wdata (cfg_wdata),
      .cfg_rdata (cfg_rdata),
      .bus_req   (bus_req),
      .bus_gnt   (bus_gnt),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_rdata   (m_rdata),
      .m_rw_     (m_rw_),
      .irq       (irq)
   );

   // one clock: bus activity is observed at the falling edge
   task automatic tick();
      @(negedge clk);
      if (bus_req) any_req = 1'b1;
      if (bus_gnt && !m_rw_) begin
         mem[m_addr] = m_wdata;
         wq.push_back({m_addr, m_wdata});
      end
      if (cfg_addr == 3'd6) st_busy = cfg_rdata[0];
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
      cfg_addr  = a;
      cfg_we    = 1'b1;
      cfg_wdata = d;
      tick();
      cfg_we    = 1'b0;
   endtask

   task automatic cfg_read(input logic [2:0] a, output logic [7:0] d);
      cfg_addr = a;
      #1;
      d = cfg_rdata;
   endtask

   task automatic program_cfg(input logic [9:0] src, input logic [9:0] dst,
                              input int len);
      cfg_write(3'd0, src[7:0]);
      cfg_write(3'd1, {6'b0, src[9:8]});
      cfg_write(3'd2, dst[7:0]);
      cfg_write(3'd3, {6'b0, dst[9:8]});
      cfg_write(3'd4, 8'(len));
   endtask

   task automatic run_copy(input logic [9:0] src, input logic [9:0] dst,
                           input int len, input string tag);
      logic [7:0]  ref_mem [1024];
      logic [17:0] exp_q[$];
      logic [9:0]  sa;
      logic [9:0]  da;
      logic [7:0]  r;
      int          grants;
      int          exp_busy;
      int          busy_cnt;
      ref_mem = mem;
      for (int i = 0; i < len; i++) begin
         sa = 10'(src + 10'(i));
         da = 10'(dst + 10'(i));
         ref_mem[da] = ref_mem[sa];
         exp_q.push_back({da, ref_mem[da]});
      end
      // REQ plus one read and one write per byte each need a grant
      exp_busy = -1;
      if (len == 0) begin
         exp_busy = 1;
      end else begin
         grants = 0;
         for (int c = 0; c < 512; c++) begin
            if (gnt_pat[c]) grants++;
            if (grants == 2 * len + 1 && exp_busy < 0) exp_busy = c + 2;
         end
      end
      bus_gnt = 1'b0;
      program_cfg(src, dst, len);
      wq.delete();
      any_req = 1'b0;
      cfg_write(3'd5, 8'h05);
      cfg_addr = 3'd6;
      busy_cnt = 0;
      for (int c = 0; c < 500; c++) begin
         bus_gnt = gnt_pat[c];
         tick();
         if (!st_busy) break;
         busy_cnt++;
      end
      bus_gnt = 1'b0;
      checks++;
      if (busy_cnt !== exp_busy) begin
         failures++;
         $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_cnt, exp_busy);
      end
      checks++;
      if (wq.size() !== exp_q.size()) begin
         failures++;
         $display("FAIL %s write_count: got %0d want %0d", tag, wq.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (wq[i] !== exp_q[i]) begin
               failures++;
               $display("FAIL %s write[%0d] addr/data: got %05h want %05h",
                        tag, i, wq[i], exp_q[i]);
            end
         end
      end
      cfg_read(3'd6, r);
      checks++;
      if (r !== 8'h02) begin
         failures++;
         $display("FAIL %s status: got %02h want 02", tag, r);
      end
      checks++;
      if (irq !== 1'b1) begin
         failures++;
         $display("FAIL %s irq: got %b want 1", tag, irq);
      end
      cfg_read(3'd7, r);
      checks++;
      if (r !== 8'h00) begin
         failures++;
         $display("FAIL %s remain: got %02h want 00", tag, r);
      end
      if (len == 0) begin
         checks++;
         if (any_req !== 1'b0) begin
            failures++;
            $display("FAIL %s bus_req_seen: got %b want 0", tag, any_req);
         end
      end
      tick();
   endtask

   task automatic fill_gnt(input int hole_a, input int hole_b);
      for (int c = 0; c < 512; c++) gnt_pat[c] = 1'b1;
      if (hole_a >= 0) gnt_pat[hole_a] = 1'b0;
      if (hole_b >= 0) gnt_pat[hole_b] = 1'b0;
   endtask

   task automatic preload();
      mem[10'h120] = 8'h99;
      mem[10'h121] = 8'hAA;
      mem[10'h122] = 8'hBB;
      mem[10'h123] = 8'hCC;
   endtask

   task automatic test_reset();
      logic [7:0] r;
      for (int a = 0; a < 8; a++) begin
         cfg_read(3'(a), r);
         checks++;
         if (r !== 8'h00) begin
            failures++;
            $display("FAIL reset reg%0d: got %02h want 00", a, r);
         end
         tick();
      end
      checks++;
      if ({bus_req, m_rw_, irq, m_addr, m_wdata} !== {3'b010, 18'h0}) begin
         failures++;
         $display("FAIL reset bus: got req=%b rw=%b irq=%b addr=%h wd=%h want 0 1 0 0 0",
                  bus_req, m_rw_, irq, m_addr, m_wdata);
      end
   endtask

   task automatic test_basic();
      logic [7:0] r;
      preload();
      fill_gnt(-1, -1);
      run_copy(10'h120, 10'h020, 4, "basic");
      cfg_read(3'd5, r);
      checks++;
      if (r !== 8'h04) begin
         failures++;
         $display("FAIL ctrl_read: got %02h want 04", r);
      end
      cfg_write(3'd6, 8'h00);
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL irq_clear: got %b want 0", irq);
      end
      cfg_read(3'd6, r);
      checks++;
      if (r !== 8'h00) begin
         failures++;
         $display("FAIL status_clear: got %02h want 00", r);
      end
      tick();
   endtask

   task automatic test_stall();
      preload();
      fill_gnt(3, 7);
      run_copy(10'h120, 10'h020, 4, "stall");
   endtask

   task automatic test_wrap();
      fill_gnt(-1, -1);
      run_copy(10'h3FE, 10'h1FF, 3, "wrap");
   endtask

   task automatic test_len0();
      fill_gnt(-1, -1);
      run_copy(10'h055, 10'h066, 0, "len0");
   endtask

   task automatic test_start_busy();
      logic [7:0] r;
      logic [17:0] exp_q[$];
      preload();
      for (int i = 0; i < 4; i++) exp_q.push_back({10'(10'h030 + 10'(i)), mem[10'h120 + i]});
      program_cfg(10'h120, 10'h030, 4);
      wq.delete();
      bus_gnt = 1'b1;
      cfg_write(3'd5, 8'h05);
      tick();
      tick();
      tick();
      cfg_read(3'd7, r);
      checks++;
      if (r !== 8'd3) begin
         failures++;
         $display("FAIL busy_remain1: got %0d want 3", r);
      end
      cfg_write(3'd5, 8'h05);
      cfg_write(3'd4, 8'd9);
      cfg_read(3'd7, r);
      checks++;
      if (r !== 8'd2) begin
         failures++;
         $display("FAIL busy_remain2: got %0d want 2", r);
      end
      cfg_addr = 3'd6;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (!st_busy) break;
      end
      bus_gnt = 1'b0;
      checks++;
      if (wq !== exp_q) begin
         failures++;
         $display("FAIL busy_start writes: got %0d entries want %0d", wq.size(), exp_q.size());
      end
      cfg_read(3'd4, r);
      checks++;
      if (r !== 8'd4) begin
         failures++;
         $display("FAIL busy_len_write: got %0d want 4", r);
      end
      tick();
   endtask

   task automatic test_abort();
      logic [7:0] r;
      logic [17:0] exp_q[$];
      preload();
      exp_q.push_back({10'h020, 8'h99});
      exp_q.push_back({10'h021, 8'hAA});
      program_cfg(10'h120, 10'h020, 4);
      wq.delete();
      bus_gnt = 1'b1;
      cfg_write(3'd5, 8'h05);
      for (int i = 0; i < 5; i++) tick();
      cfg_write(3'd5, 8'h06);
      bus_gnt = 1'b0;
      checks++;
      if (bus_req !== 1'b0) begin
         failures++;
         $display("FAIL abort bus_req: got %b want 0", bus_req);
      end
      cfg_read(3'd6, r);
      checks++;
      if (r !== 8'h04) begin
         failures++;
         $display("FAIL abort status: got %02h want 04", r);
      end
      cfg_read(3'd7, r);
      checks++;
      if (r !== 8'd2) begin
         failures++;
         $display("FAIL abort remain: got %0d want 2", r);
      end
      checks++;
      if (wq !== exp_q) begin
         failures++;
         $display("FAIL abort writes: got %0d entries want 2", wq.size());
      end
      tick();
   endtask

   task automatic test_idle_abort();
      logic [7:0] r;
      cfg_write(3'd6, 8'h00);
      any_req = 1'b0;
      cfg_write(3'd5, 8'h07);
      tick();
      cfg_read(3'd6, r);
      checks++;
      if (r !== 8'h00 || any_req !== 1'b0) begin
         failures++;
         $display("FAIL start_abort: got status %02h req %b want 00 0", r, any_req);
      end
      tick();
   endtask

   task automatic test_random();
      logic [9:0] s;
      logic [9:0] d;
      int         n;
      for (int k = 0; k < 6; k++) begin
         s = 10'($urandom);
         d = 10'($urandom);
         n = int'($urandom_range(1, 12));
         for (int c = 0; c < 512; c++)
            gnt_pat[c] = (c >= 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
         run_copy(s, d, n, $sformatf("rand%0d", k));
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] r;
      preload();
      program_cfg(10'h120, 10'h020, 4);
      wq.delete();
      bus_gnt = 1'b1;
      cfg_write(3'd5, 8'h05);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      any_req = 1'b0;
      cfg_addr = 3'd0;
      for (int i = 0; i < 4; i++) tick();
      bus_gnt = 1'b0;
      checks++;
      if (wq.size() !== 1 || any_req !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid bus: got %0d writes req %b want 1 0", wq.size(), any_req);
      end
      for (int a = 0; a < 8; a++) begin
         cfg_read(3'(a), r);
         checks++;
         if (r !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid reg%0d: got %02h want 00", a, r);
         end
         tick();
      end
   endtask

   initial begin
      reset     = 1'b1;
      cfg_addr  = 3'd0;
      cfg_we    = 1'b0;
      cfg_wdata = 8'h00;
      bus_gnt   = 1'b0;
      st_busy   = 1'b0;
      any_req   = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      @(posedge clk);
      #1;
      tick();
      reset = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_len0();
      test_start_busy();
      test_abort();
      test_idle_abort();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
